// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared types, MISR seed and reference gate function for the gate BIST checker.
package gate_bist_pkg;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR} op_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [63:0] MISR_SEED = '1;
  function automatic logic [63:0] ref_op(op_e op, logic [63:0] a, logic [63:0] b);
    return (op == OP_OR) ? (a | b) : (op == OP_XOR) ? (a ^ b) : (a & b);
  endfunction
endpackage

// File: rtl/gate_bist_misr.sv
// gate_bist_misr: multiple-input signature register, seeded to all ones on clear.
module gate_bist_misr
  import gate_bist_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] MISR_POLY = WIDTH'(32'h04C11DB7)
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] sig_o
);
  logic [WIDTH-1:0] r_sig;
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) r_sig <= '0;
    else if (clr_i) r_sig <= MISR_SEED[WIDTH-1:0];
    else if (en_i) r_sig <= {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? MISR_POLY : '0) ^ data_i;
  assign sig_o = r_sig;
endmodule

// File: rtl/gate_bist_checker.sv
// gate_bist_checker: response analyser for AND/OR/XOR gate self-test (counts mismatches, logs first failure).
// Define GATE_BIST_MISR_EN to add a signature register on signature_o; otherwise signature_o is 0.
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               N_VECTORS = 16,
  parameter int               CNT_W     = 8,
  parameter op_e              OP        = OP_AND,
  parameter logic [WIDTH-1:0] MISR_POLY = WIDTH'(32'h04C11DB7)
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             start_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] s_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [CNT_W-1:0] first_err_idx_o,
  output logic [WIDTH-1:0] first_err_val_o,
  output logic [WIDTH-1:0] signature_o
);
  if (N_VECTORS < 1 || N_VECTORS > (1 << CNT_W)) begin : g_bad_n
    $error("gate_bist_checker: N_VECTORS must be in 1..2**CNT_W");
  end
  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_w
    $error("gate_bist_checker: WIDTH must be in 2..64");
  end
  state_e           r_state, w_next;
  logic [CNT_W-1:0] r_vec, r_err, r_idx;
  logic [WIDTH-1:0] r_val, w_exp;
  logic             r_seen, w_clr, w_acc, w_mis, w_last;
  assign w_exp  = WIDTH'(ref_op(OP, 64'(a_i), 64'(b_i)));
  assign w_clr  = start_i && (r_state != RUN);
  assign w_acc  = valid_i && (r_state == RUN);
  assign w_mis  = w_acc && (s_i != w_exp);
  assign w_last = r_vec == CNT_W'(N_VECTORS - 1);
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == RUN) ? ((w_acc && w_last) ? DONE : RUN) : (start_i ? RUN : r_state);
  end
  // A vector arriving together with start is dropped: w_acc needs RUN already.
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) begin
      r_vec  <= '0;
      r_err  <= '0;
      r_idx  <= '0;
      r_val  <= '0;
      r_seen <= 1'b0;
    end else if (w_clr) begin
      r_vec  <= '0;
      r_err  <= '0;
      r_idx  <= '0;
      r_val  <= '0;
      r_seen <= 1'b0;
    end else if (w_acc) begin
      r_vec <= r_vec + 1'b1;
      if (w_mis) begin
        r_err <= (r_err == '1) ? r_err : r_err + 1'b1;
        if (!r_seen) begin
          r_idx  <= r_vec;
          r_val  <= s_i;
          r_seen <= 1'b1;
        end
      end
    end
  assign busy_o          = r_state == RUN;
  assign done_o          = r_state == DONE;
  assign pass_o          = done_o && (r_err == '0);
  assign err_count_o     = r_err;
  assign first_err_idx_o = r_idx;
  assign first_err_val_o = r_val;
`ifdef GATE_BIST_MISR_EN
  gate_bist_misr #(.WIDTH(WIDTH), .MISR_POLY(MISR_POLY)) u_misr (
    .clk_i   (clk_i),
    .resetn_i(resetn_i),
    .clr_i   (w_clr),
    .en_i    (w_acc),
    .data_i  (s_i),
    .sig_o   (signature_o)
  );
`else
  logic w_unused;
  assign w_unused    = ^MISR_POLY;
  assign signature_o = '0;
`endif
endmodule

// File: tb/tb_gate_bist_checker.sv
// tb_gate_bist_checker: randomized runs against a vector-list reference model, AND (8-bit counters) and XOR (2-bit counters) instances.
module tb_gate_bist_checker;
  import gate_bist_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, valid = 1'b0;
  logic [31:0] a = '0, b = '0, s = '0;
  logic busy_a, done_a, pass_a, busy_x, done_x, pass_x;
  logic [7:0] err_a, idx_a;
  logic [1:0] err_x, idx_x;
  logic [31:0] val_a, sig_a, val_x, sig_x;
  logic [31:0] va[N], vb[N], vs[N];
  int n_tests = 0, n_fail = 0;

  gate_bist_checker #(.WIDTH(32), .N_VECTORS(N), .CNT_W(8), .OP(OP_AND)) dut_a (
    .clk_i(clk), .resetn_i(resetn), .start_i(start), .valid_i(valid), .a_i(a), .b_i(b), .s_i(s),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .err_count_o(err_a),
    .first_err_idx_o(idx_a), .first_err_val_o(val_a), .signature_o(sig_a));
  gate_bist_checker #(.WIDTH(32), .N_VECTORS(N), .CNT_W(2), .OP(OP_XOR)) dut_x (
    .clk_i(clk), .resetn_i(resetn), .start_i(start), .valid_i(valid), .a_i(a), .b_i(b), .s_i(s),
    .busy_o(busy_x), .done_o(done_x), .pass_o(pass_x), .err_count_o(err_x),
    .first_err_idx_o(idx_x), .first_err_val_o(val_x), .signature_o(sig_x));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] misr_step(input logic [31:0] sg, input logic [31:0] d);
    return {sg[30:0], 1'b0} ^ (sg[31] ? 32'h04C11DB7 : 32'h0) ^ d;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, {busy_a, busy_x}, 0);
    check({tag, "_done"}, {done_a, done_x}, 0);
    check({tag, "_pass"}, {pass_a, pass_x}, 0);
    check({tag, "_err"}, {err_a, err_x}, 0);
    check({tag, "_idx"}, {idx_a, idx_x}, 0);
    check({tag, "_val"}, {val_a, val_x}, 0);
    check({tag, "_sig"}, {sig_a, sig_x}, 0);
  endtask

  task automatic fill_random(input bit xor_ok);
    for (int i = 0; i < N; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
      vs[i] = xor_ok ? (va[i] ^ vb[i]) : (va[i] & vb[i]);
      if ($urandom_range(3, 0) == 0) vs[i] = vs[i] ^ (32'h1 << $urandom_range(31, 0));
    end
  endtask

  task automatic run(input int smin, input int smax, input bit mid_start, input bit start_valid);
    int ea = 0, ex = 0, fa = -1, fx = -1;
    logic [31:0] fva = '0, fvx = '0, sg = 32'hFFFF_FFFF;
    start = 1'b1;
    valid = start_valid;
    a = $urandom;
    b = $urandom;
    s = $urandom;
    tick;
    start = 1'b0;
    valid = 1'b0;
    check("start_busy", {busy_a, busy_x}, 2'b11);
    check("start_clear", {done_a, pass_a, err_a, err_x}, 0);
    for (int i = 0; i < N; i++) begin
      int st = $urandom_range(smax, smin);
      for (int k = 0; k < st; k++) begin
        start = mid_start && (k == 0);
        valid = 1'b0;
        a = $urandom;
        s = $urandom;
        tick;
      end
      start = 1'b0;
      a = va[i];
      b = vb[i];
      s = vs[i];
      valid = 1'b1;
      tick;
      valid = 1'b0;
      if (vs[i] != (va[i] & vb[i])) begin
        if (fa < 0) begin fa = i; fva = vs[i]; end
        ea++;
      end
      if (vs[i] != (va[i] ^ vb[i])) begin
        if (fx < 0) begin fx = i; fvx = vs[i]; end
        ex++;
      end
      sg = misr_step(sg, vs[i]);
      check("err_a", err_a, ea);
      check("err_x_sat", err_x, (ex > 3) ? 3 : ex);
      check("busy", {busy_a, busy_x}, (i < N - 1) ? 2'b11 : 2'b00);
      check("done", {done_a, done_x}, (i == N - 1) ? 2'b11 : 2'b00);
    end
    check("pass_a", pass_a, ea == 0);
    check("pass_x", pass_x, ex == 0);
    check("idx_a", idx_a, (fa < 0) ? 0 : fa);
    check("idx_x", idx_x, (fx < 0) ? 0 : fx);
    check("val_a", val_a, fva);
    check("val_x", val_x, fvx);
`ifdef GATE_BIST_MISR_EN
    check("sig", {sig_a, sig_x}, {sg, sg});
`else
    check("sig", {sig_a, sig_x}, 0);
`endif
    for (int k = 0; k < 2; k++) begin
      valid = 1'b1;
      s = ~vs[0];
      tick;
    end
    valid = 1'b0;
    check("hold", {done_a, err_a, idx_a, val_a}, {1'b1, 8'(ea), 8'((fa < 0) ? 0 : fa), fva});
  endtask

  initial begin
    tick;
    tick;
    check_zero("reset");
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1;
      a = $urandom;
      b = $urandom;
      s = $urandom;
      tick;
    end
    valid = 1'b0;
    check_zero("idle_valid");
    va = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
    vb = '{32'h0, 32'h0, 32'hFFFF_0000, 32'hFFFF_0000};
    vs = '{32'h0, 32'h0, 32'hFFFF_0000, 32'h1234_0000};
    run(0, 0, 1'b0, 1'b0);
    check("clean_pass", {pass_a, err_a}, {1'b1, 8'd0});
    vs[2] = 32'hFFFF_0001;
    vs[3] = 32'h1234_0001;
    run(0, 0, 1'b0, 1'b0);
    check("fail_run", {pass_a, err_a, idx_a, val_a}, {1'b0, 8'd2, 8'd2, 32'hFFFF_0001});
    vs[2] = 32'hFFFF_0000;
    vs[3] = 32'h1234_0000;
    run(3, 3, 1'b1, 1'b1);
    check("stall_pass", {pass_a, err_a}, {1'b1, 8'd0});
    vs[0] = 32'h1;
    vs[1] = 32'h2;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = va[i];
      b = vb[i];
      s = vs[i];
      valid = 1'b1;
      tick;
    end
    valid = 1'b0;
    check("pre_reset_err", err_a, 2);
    #3 resetn = 1'b0;
    #1 check_zero("async_reset");
    tick;
    resetn = 1'b1;
    vs[0] = 32'h0;
    vs[1] = 32'h0;
    run(0, 1, 1'b0, 1'b0);
    check("after_reset_pass", pass_a, 1'b1);
    for (int i = 0; i < N; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
      vs[i] = 32'h0;
    end
    run(0, 0, 1'b0, 1'b0);
`ifdef GATE_BIST_MISR_EN
    check("sig_zero_resp", sig_x, 32'hC7B0_424D);
`else
    check("sig_zero_resp", sig_x, 32'h0);
`endif
    for (int r = 0; r < 24; r++) begin
      fill_random(1'($urandom_range(1, 0)));
      run(0, 2, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
